// File: rtl/ln_stage2_stats_if.sv
// Request/result bundle for ln_stage2_stats (LayerNorm stage 2).
// Optional o_var is present only when LN_STATS_VAR_OUT_EN is defined.
// Handshake: a request transfers on a rising edge where i_valid and o_ready
// are both high; o_valid is a single-cycle pulse with no back-pressure, so
// the consumer must take the result in that cycle.
interface ln_stage2_stats_if #(
  parameter int SUM_W = 32,
  parameter int SQ_W  = 48
);
  logic             i_valid;
  logic [SUM_W-1:0] i_sum;       // two's complement sum of Q.10 elements
  logic [SQ_W-1:0]  i_sumsq;     // unsigned sum of squares, Q.20
  logic             o_ready;
  logic             o_valid;
  logic [31:0]      o_mean;      // two's complement mean, Q.10
  logic [16:0]      o_inv_sqrt;  // inverse std, Q.10, bit 16 always 0
`ifdef LN_STATS_VAR_OUT_EN
  logic [47:0]      o_var;       // clamped variance + EPS, Q.20
`endif
  logic [1:0]       dbg_state;   // FSM state for observation

  modport slave (
    input  i_valid, i_sum, i_sumsq,
    output o_ready, o_valid, o_mean, o_inv_sqrt,
`ifdef LN_STATS_VAR_OUT_EN
    output o_var,
`endif
    output dbg_state
  );

  modport master (
    output i_valid, i_sum, i_sumsq,
    input  o_ready, o_valid, o_mean, o_inv_sqrt,
`ifdef LN_STATS_VAR_OUT_EN
    input  o_var,
`endif
    input  dbg_state
  );
endinterface

// File: rtl/ln_stage2_stats.sv
// LayerNorm stage 2: per-token sum / sum-of-squares -> mean and 1/std (Q.10).
// Optional feature macro: LN_STATS_VAR_OUT_EN (exposes the clamped var+EPS).
// 1/sqrt is found by a 16-step bit-serial search, so latency is fixed:
// accept, STATS (1), SEARCH (16), DONE (1, o_valid), back to IDLE.
module ln_stage2_stats #(
  parameter int          LOG2_N = 6,
  parameter int          SUM_W  = 32,
  parameter int          SQ_W   = 48,
  parameter int unsigned EPS    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ln_stage2_stats_if.slave    bus
);

  // Signed width wide enough for ex2 - mean*mean without overflow.
  localparam int VW = 66;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATS  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic load_in, do_stats, do_step, do_result;
  logic ready_c, valid_c;

  logic [SUM_W-1:0] sum_r;
  logic [SQ_W-1:0]  sumsq_r;
  logic [31:0]      mean_r;
  logic [47:0]      var_r;
  logic [15:0]      y_r;
  logic [3:0]       b_r;

  logic [31:0]      mean_q;
  logic [16:0]      inv_q;
`ifdef LN_STATS_VAR_OUT_EN
  logic [47:0]      var_q;
`endif

  logic signed [SUM_W-1:0] sum_sh;
  logic signed [31:0]      mean_c;
  logic [SQ_W-1:0]         ex2_c;
  logic signed [VW-1:0]    mean_x;
  logic signed [VW-1:0]    ex2_x;
  logic signed [VW-1:0]    var_full;
  logic [47:0]             var_c;
  logic [15:0]             t_c;
  logic [79:0]             prod_c;
  logic                    fit_c;
  logic [15:0]             y_nxt;

  // State register; reset returns to IDLE from anywhere, aborting a job.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    do_stats  = 1'b0;
    do_step   = 1'b0;
    do_result = 1'b0;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.i_valid) begin
          load_in   = 1'b1;
          state_nxt = ST_STATS;
        end
      end
      ST_STATS: begin
        do_stats  = 1'b1;
        state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        do_step = 1'b1;
        if (b_r == 4'd0) begin
          do_result = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_c   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Mean and variance: divide by N with shifts, clamp negative var, add EPS.
  always_comb begin
    sum_sh   = $signed(sum_r) >>> LOG2_N;
    mean_c   = 32'(sum_sh);
    ex2_c    = sumsq_r >> LOG2_N;
    mean_x   = VW'(mean_c);
    ex2_x    = $signed(VW'(ex2_c));
    var_full = ex2_x - mean_x * mean_x;
    var_c    = var_full[VW-1] ? 48'd0 : (48'(var_full) + 48'(EPS));
  end

  // One search step: keep bit b if (y|bit)^2 * var still fits under 2^40.
  always_comb begin
    t_c    = y_r | (16'd1 << b_r);
    prod_c = 80'(t_c) * 80'(t_c) * 80'(var_r);
    fit_c  = (prod_c <= (80'd1 << 40));
    y_nxt  = fit_c ? t_c : y_r;
  end

  // Datapath registers and held result outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_r   <= '0;
      sumsq_r <= '0;
      mean_r  <= '0;
      var_r   <= '0;
      y_r     <= '0;
      b_r     <= '0;
      mean_q  <= '0;
      inv_q   <= '0;
`ifdef LN_STATS_VAR_OUT_EN
      var_q   <= '0;
`endif
    end else begin
      if (load_in) begin
        sum_r   <= bus.i_sum;
        sumsq_r <= bus.i_sumsq;
      end
      if (do_stats) begin
        mean_r <= mean_c;
        var_r  <= var_c;
        y_r    <= '0;
        b_r    <= 4'd15;
      end
      if (do_step) begin
        y_r <= y_nxt;
        b_r <= b_r - 4'd1;
      end
      if (do_result) begin
        mean_q <= mean_r;
        inv_q  <= {1'b0, y_nxt};
`ifdef LN_STATS_VAR_OUT_EN
        var_q  <= var_r;
`endif
      end
    end
  end

  assign bus.o_ready    = ready_c;
  assign bus.o_valid    = valid_c;
  assign bus.o_mean     = mean_q;
  assign bus.o_inv_sqrt = inv_q;
`ifdef LN_STATS_VAR_OUT_EN
  assign bus.o_var      = var_q;
`endif
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_ln_stage2_stats.sv
// Directed bench for ln_stage2_stats: one instance with EPS=0, one with the
// default EPS=16, both fed the same requests. Honours LN_STATS_VAR_OUT_EN.
module tb_ln_stage2_stats;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  ln_stage2_stats_if bus0 ();
  ln_stage2_stats_if bus1 ();

  ln_stage2_stats #(.EPS(0)) dut0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus0)
  );

  ln_stage2_stats dut1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {mean[31:0], inv_eps0[16:0], inv_eps16[16:0]}
  logic [65:0] exp_q[$];
  logic [31:0] acc_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic v, input logic [31:0] sum, input logic [47:0] sq);
    bus0.i_valid = v; bus0.i_sum = sum; bus0.i_sumsq = sq;
    bus1.i_valid = v; bus1.i_sum = sum; bus1.i_sumsq = sq;
  endtask

  // Called at posedge+1 with both DUTs idle; returns at posedge+1, idle again.
  task automatic run_job(input string tag, input logic [31:0] sum, input logic [47:0] sq,
                         input logic [31:0] em, input logic [16:0] ei0, input logic [16:0] ei1,
                         input logic [47:0] ev0, input logic [47:0] ev1);
    int n;
    int ready_hi;
    logic [65:0] e;
    exp_q.push_back({em, ei0, ei1});
    drive_req(1'b1, sum, sq);
    @(negedge i_clk);
    check({tag, "_rdy"}, bus0.o_ready, 1);
    @(posedge i_clk); #1;
    drive_req(1'b0, $urandom, 48'($urandom));
    n = 1;
    ready_hi = 0;
    while (n < 40) begin
      @(negedge i_clk);
      if (bus0.o_ready || bus1.o_ready) ready_hi++;
      if (bus0.o_valid) break;
      @(posedge i_clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 18);
    check({tag, "_busy_ready"}, ready_hi, 0);
    check({tag, "_vld1"}, bus1.o_valid, 1);
    e = exp_q.pop_front();
    check({tag, "_mean0"}, bus0.o_mean, e[65:34]);
    check({tag, "_mean1"}, bus1.o_mean, e[65:34]);
    check({tag, "_inv0"}, bus0.o_inv_sqrt, e[33:17]);
    check({tag, "_inv1"}, bus1.o_inv_sqrt, e[16:0]);
`ifdef LN_STATS_VAR_OUT_EN
    check({tag, "_var0"}, bus0.o_var, ev0);
    check({tag, "_var1"}, bus1.o_var, ev1);
`else
    if (ev0 != ev1) begin end
`endif
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check({tag, "_pulse"}, bus0.o_valid, 0);
    check({tag, "_idle"}, bus0.o_ready, 1);
    check({tag, "_hold"}, bus0.o_inv_sqrt, e[33:17]);
    @(posedge i_clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc_n;
    int vld_n;
    int busy_rdy;

    i_rst_n = 1'b0;
    drive_req(1'b0, '0, '0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", bus0.o_ready, 1);
    check("rst_valid", bus0.o_valid, 0);
    check("rst_mean", bus0.o_mean, 0);
    check("rst_inv", bus0.o_inv_sqrt, 0);
    check("rst_state", bus0.dbg_state, 0);
`ifdef LN_STATS_VAR_OUT_EN
    check("rst_var", bus0.o_var, 0);
`endif
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // tag, sum, sumsq, mean, inv(EPS=0), inv(EPS=16), var(EPS=0), var(EPS=16)
    run_job("unit", 32'd65536, 48'd134217728, 32'd1024, 17'd1024, 17'd1023,
            48'd1048576, 48'd1048592);
    run_job("var4", 32'd131072, 48'd536870912, 32'd2048, 17'd512, 17'd511,
            48'd4194304, 48'd4194320);
    run_job("neg", 32'hFFFF_8000, 48'd16777216, 32'hFFFF_FE00, 17'd65535, 17'd65535,
            48'd0, 48'd16);
    run_job("clamp", 32'd65536, 48'd0, 32'd1024, 17'd65535, 17'd65535,
            48'd0, 48'd16);
    run_job("var9", 32'd0, 48'd603979776, 32'd0, 17'd341, 17'd341,
            48'd9437184, 48'd9437200);

    // Streaming: i_valid held high with fresh data; reset in cycle 10 of job 2.
    acc_q.push_back(32'd0);
    acc_q.push_back(32'd19);
    acc_n = 0;
    vld_n = 0;
    busy_rdy = 0;
    for (int c = 0; c < 60; c++) begin
      i_rst_n = (c == 29) ? 1'b0 : 1'b1;
      if (c == 0)      drive_req(1'b1, 32'd65536, 48'd134217728);
      else if (c < 30) drive_req(1'b1, 32'(c * 64), 48'($urandom));
      else             drive_req(1'b0, '0, '0);
      @(negedge i_clk);
      if (bus0.i_valid && bus0.o_ready && i_rst_n) begin
        acc_n++;
        if (acc_q.size() > 0) check("stream_acc_cycle", c, acc_q.pop_front());
        else                  check("stream_acc_extra", c, 32'hFFFF);
      end
      if (c >= 1 && c <= 18 && bus0.o_ready) busy_rdy++;
      if (bus0.o_valid) begin
        vld_n++;
        check("stream_vld_cycle", c, 18);
        check("stream_mean", bus0.o_mean, 32'd1024);
        check("stream_inv", bus0.o_inv_sqrt, 17'd1024);
      end
      if (c == 30) begin
        check("post_rst_ready0", bus0.o_ready, 1);
        check("post_rst_ready1", bus1.o_ready, 1);
        check("post_rst_mean", bus0.o_mean, 0);
        check("post_rst_inv", bus0.o_inv_sqrt, 0);
        check("post_rst_inv1", bus1.o_inv_sqrt, 0);
`ifdef LN_STATS_VAR_OUT_EN
        check("post_rst_var", bus1.o_var, 0);
`endif
      end
      @(posedge i_clk); #1;
    end
    check("stream_acc_count", acc_n, 2);
    check("stream_vld_count", vld_n, 1);
    check("stream_busy_ready", busy_rdy, 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ln_stage2_stats.md
Name: ln_stage2_stats

Overview:
- Stage 2 of the LayerNorm pipeline. Converts the per-token sum and sum-of-squares from stage 1 into mean (Q.10) and inverse standard deviation (Q.10).
- Its outputs drive i_mean / i_inv_sqrt / i_valid_trigger of ln_stage3_normalize.
- Raw-data alignment for stage 3 is handled outside this block.
- Inverse square root uses a deterministic bit-serial search, so latency is fixed.

Parameters:
- LOG2_N, 6, log2 of elements per token (64 channels); division by N is an arithmetic shift.
- SUM_W, 32, width of signed i_sum.
- SQ_W, 48, width of unsigned i_sumsq.
- EPS, 16, epsilon added to variance, unsigned Q.20.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  stats request; accepted when i_valid & o_ready at a rising edge.
- i_sum  in  SUM_W  signed sum of Q.10 elements.
- i_sumsq  in  SQ_W  unsigned sum of squares, Q.20.
- o_ready  out  1  high only in IDLE.
- o_valid  out  1  one-cycle result pulse (feeds i_valid_trigger).
- o_mean  out  32  signed mean, Q.10.
- o_inv_sqrt  out  17  signed inverse std, Q.10; bit 16 is always 0.

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE, o_ready=1, o_valid=0, o_mean=0, o_inv_sqrt=0, search registers cleared.
- Reset has priority over everything. Reset mid-operation aborts with no o_valid; o_ready=1 in the first cycle after release.
- FSM: IDLE -> STATS -> SEARCH (16 cycles) -> DONE -> IDLE.
- IDLE: o_ready=1. On accept, register i_sum and i_sumsq, go to STATS. Inputs are ignored in all other states.
- STATS (1 cycle):
  - mean = i_sum >>> LOG2_N, sign-extended to 32 bits.
  - ex2 = i_sumsq >> LOG2_N.
  - var = ex2 - mean*mean, computed signed at full width. Clamp to 0 if negative, then add EPS (48-bit result).
  - Set y=0, bit index b=15.
- SEARCH: each cycle, t = y | (1<<b). If t*t*var <= 2^40 (80-bit unsigned compare), y = t. Decrement b. Leave after b=0.
- Result: y = floor(2^20 / sqrt(var)), saturating naturally at 65535. var=0 gives 65535.
- DONE (1 cycle): o_valid=1. o_mean and o_inv_sqrt = {1'b0, y} are updated on the edge entering DONE and held until the next DONE.
- Latency: accept in cycle 0 -> o_valid high in cycle 18. o_ready low in cycles 1–18. Earliest next accept is cycle 19, giving throughput 1 per 19 cycles.
- No output back-pressure. Downstream must take the o_valid pulse.
- i_valid held high continuously: accepts at cycles 0, 19, 38, ...

Optional Feature:
- Macro LN_STATS_VAR_OUT_EN.
- Defined: adds output port o_var [47:0], the clamped var+EPS value. It is registered on the same edge as o_inv_sqrt and is 0 at reset.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- EPS=0, i_sum=65536, i_sumsq=2^27 (alternating 0 / 2.0) -> o_mean=1024, o_inv_sqrt=1024, o_valid in cycle 18 after accept.
- EPS=0, i_sum=2^17, i_sumsq=2^29 (var=4.0) -> o_mean=2048, o_inv_sqrt=512. With LN_STATS_VAR_OUT_EN, o_var=2^22.
- EPS=0, i_sum=-32768, i_sumsq=2^24 -> o_mean=32'hFFFF_FE00, var=0, o_inv_sqrt=65535.
- EPS=0, i_sum=65536, i_sumsq=0 (negative variance) -> clamp to 0, o_inv_sqrt=65535, o_mean=1024.
- Default EPS=16, i_sum=65536, i_sumsq=2^27 -> var=2^20+16, o_inv_sqrt=1023.
- i_valid held high with new data each cycle -> accepts only at cycles 0 and 19, o_ready low in 1–18. Reset asserted in cycle 10 of the second job -> no o_valid for that job, all outputs 0, o_ready=1 after release.
